// File: rtl/tcm_mem_ram_dp.sv
// Parametrised true dual-port TCM: port 0 = instruction side, port 1 = data/debug side.
// Memory is cleared to INIT_VALUE after reset and ready_o rises once the clear completes.
module tcm_mem_ram_dp #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 14,
  parameter bit                WRITE_FIRST = 1'b0,
  parameter bit                OUT_REG     = 1'b0,
  parameter bit                INIT_CLEAR  = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE  = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   addr0_i,
  input  logic [DATA_W-1:0]   data0_i,
  input  logic [DATA_W/8-1:0] wr0_i,
  input  logic                rd0_i,
  output logic [DATA_W-1:0]   data0_o,
  output logic                valid0_o,
  input  logic [ADDR_W-1:0]   addr1_i,
  input  logic [DATA_W-1:0]   data1_i,
  input  logic [DATA_W/8-1:0] wr1_i,
  input  logic                rd1_i,
  output logic [DATA_W-1:0]   data1_o,
  output logic                valid1_o,
  output logic                ready_o,
  output logic                collision_o,
  output logic                state_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              ready_q;
  logic              coll_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0][NB-1:0]     be;
  logic [1:0]             rd;
  logic [1:0]             acc;

  // Requests carry no handshake: an access is taken on any edge where ready_o=1 and
  // rd or a write enable is set; valid pulses exactly once, READ_LATENCY later, per rd.
  assign addr  = {addr1_i, addr0_i};
  assign wdata = {data1_i, data0_i};
  assign be    = ready_q ? {wr1_i, wr0_i} : '0;
  assign rd    = ready_q ? {rd1_i, rd0_i} : 2'b00;
  assign acc   = {rd[1] | (|be[1]), rd[0] | (|be[0])};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= INIT_CLEAR ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) state <= ST_READY;
        end
        ST_READY: ready_q <= 1'b1;
        default:  state <= ST_READY;
      endcase
    end
  end

  // Port 1 lanes are written first so port 0 overrides on shared lanes of a shared address.
  always_ff @(posedge clk_i) begin
    if (state == ST_CLEAR) mem[clr_cnt] <= INIT_VALUE;
    for (int b = 0; b < NB; b++) begin
      if (be[1][b]) mem[addr[1]][8*b +: 8] <= wdata[1][8*b +: 8];
      if (be[0][b]) mem[addr[0]][8*b +: 8] <= wdata[0][8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) coll_q <= 1'b0;
    else        coll_q <= (addr[0] == addr[1]) && (|(be[0] & be[1]));
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_W-1:0] old_w, new_w, s1_data, out_data;
    logic              s1_vld, out_vld;

    // Cross-port writes never show through: only this port's own lanes are merged.
    assign old_w = mem[addr[p]];
    always_comb begin
      new_w = old_w;
      for (int b = 0; b < NB; b++)
        if (be[p][b]) new_w[8*b +: 8] = wdata[p][8*b +: 8];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        s1_data <= '0;
        s1_vld  <= 1'b0;
      end else begin
        s1_vld <= rd[p];
        if (acc[p]) s1_data <= WRITE_FIRST ? new_w : old_w;
      end
    end

    if (OUT_REG) begin : g_oreg
      logic [DATA_W-1:0] s2_data;
      logic              s2_vld, s1_en;
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          s1_en   <= 1'b0;
          s2_data <= '0;
          s2_vld  <= 1'b0;
        end else begin
          s1_en  <= acc[p];
          s2_vld <= s1_vld;
          if (s1_en) s2_data <= s1_data;
        end
      end
      assign out_data = s2_data;
      assign out_vld  = s2_vld;
    end else begin : g_noreg
      assign out_data = s1_data;
      assign out_vld  = s1_vld;
    end
  end

  assign data0_o     = g_port[0].out_data;
  assign valid0_o    = g_port[0].out_vld;
  assign data1_o     = g_port[1].out_data;
  assign valid1_o    = g_port[1].out_vld;
  assign ready_o     = ready_q;
  assign collision_o = coll_q;
  assign state_o     = state;

endmodule

// File: tb/tb_tcm_mem_ram_dp.sv
// Bench for tcm_mem_ram_dp: three instances share stimulus (read-first/OUT_REG=0,
// write-first/OUT_REG=1, no-clear) and read data is checked against a spec-level model.
module tb_tcm_mem_ram_dp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  addr0 = '0, addr1 = '0;
  logic [31:0] din0 = '0, din1 = '0;
  logic [3:0]  wr0 = '0, wr1 = '0;
  logic        rd0 = 1'b0, rd1 = 1'b0;

  logic [31:0] da0, da1, db0, db1, dc0, dc1;
  logic        va0, va1, vb0, vb1, vc0, vc1;
  logic        ready_a, ready_b, ready_c, coll_a, coll_b, coll_c, st_a, st_b, st_c;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mdl [16];
  bit          bench_ready = 1'b0;
  logic [31:0] qa0[$], qa1[$], qb0[$], qb1[$];

  always #5 clk = ~clk;

  tcm_mem_ram_dp #(.DATA_W(32), .ADDR_W(4), .WRITE_FIRST(1'b0), .OUT_REG(1'b0),
                   .INIT_CLEAR(1'b1), .INIT_VALUE(32'hA5A5A5A5)) u_a (
    .clk_i(clk), .rst_i(rst),
    .addr0_i(addr0), .data0_i(din0), .wr0_i(wr0), .rd0_i(rd0), .data0_o(da0), .valid0_o(va0),
    .addr1_i(addr1), .data1_i(din1), .wr1_i(wr1), .rd1_i(rd1), .data1_o(da1), .valid1_o(va1),
    .ready_o(ready_a), .collision_o(coll_a), .state_o(st_a));

  tcm_mem_ram_dp #(.DATA_W(32), .ADDR_W(4), .WRITE_FIRST(1'b1), .OUT_REG(1'b1),
                   .INIT_CLEAR(1'b1), .INIT_VALUE(32'hA5A5A5A5)) u_b (
    .clk_i(clk), .rst_i(rst),
    .addr0_i(addr0), .data0_i(din0), .wr0_i(wr0), .rd0_i(rd0), .data0_o(db0), .valid0_o(vb0),
    .addr1_i(addr1), .data1_i(din1), .wr1_i(wr1), .rd1_i(rd1), .data1_o(db1), .valid1_o(vb1),
    .ready_o(ready_b), .collision_o(coll_b), .state_o(st_b));

  tcm_mem_ram_dp #(.DATA_W(32), .ADDR_W(4), .WRITE_FIRST(1'b0), .OUT_REG(1'b0),
                   .INIT_CLEAR(1'b0), .INIT_VALUE(32'h0)) u_c (
    .clk_i(clk), .rst_i(rst),
    .addr0_i(addr0), .data0_i(din0), .wr0_i(wr0), .rd0_i(rd0), .data0_o(dc0), .valid0_o(vc0),
    .addr1_i(addr1), .data1_i(din1), .wr1_i(wr1), .rd1_i(rd1), .data1_o(dc1), .valid1_o(vc1),
    .ready_o(ready_c), .collision_o(coll_c), .state_o(st_c));

  // Scoreboard: every valid pulse pops its port's queue.
  always @(negedge clk) begin
    logic [31:0] e;
    if (va0) begin
      n_cmp++;
      if (qa0.size() == 0) begin n_err++; $display("FAIL a_p0_unexpected_valid: data %h, nothing expected", da0); end
      else begin e = qa0.pop_front(); if (da0 !== e) begin n_err++; $display("FAIL a_p0_data: got %h expected %h", da0, e); end end
    end
    if (va1) begin
      n_cmp++;
      if (qa1.size() == 0) begin n_err++; $display("FAIL a_p1_unexpected_valid: data %h, nothing expected", da1); end
      else begin e = qa1.pop_front(); if (da1 !== e) begin n_err++; $display("FAIL a_p1_data: got %h expected %h", da1, e); end end
    end
    if (vb0) begin
      n_cmp++;
      if (qb0.size() == 0) begin n_err++; $display("FAIL b_p0_unexpected_valid: data %h, nothing expected", db0); end
      else begin e = qb0.pop_front(); if (db0 !== e) begin n_err++; $display("FAIL b_p0_data: got %h expected %h", db0, e); end end
    end
    if (vb1) begin
      n_cmp++;
      if (qb1.size() == 0) begin n_err++; $display("FAIL b_p1_unexpected_valid: data %h, nothing expected", db1); end
      else begin e = qb1.pop_front(); if (db1 !== e) begin n_err++; $display("FAIL b_p1_data: got %h expected %h", db1, e); end end
    end
  end

  // One access cycle on both ports; returns 1 time unit after the access edge.
  task automatic acc(input logic [3:0] a0, input logic [31:0] d0, input logic [3:0] w0, input logic r0,
                     input logic [3:0] a1, input logic [31:0] d1, input logic [3:0] w1, input logic r1);
    logic [31:0] old0, old1, m0, m1;
    if (bench_ready) begin
      old0 = mdl[a0]; old1 = mdl[a1]; m0 = old0; m1 = old1;
      for (int b = 0; b < 4; b++) begin
        if (w0[b]) m0[8*b +: 8] = d0[8*b +: 8];
        if (w1[b]) m1[8*b +: 8] = d1[8*b +: 8];
      end
      if (r0) begin qa0.push_back(old0); qb0.push_back(m0); end
      if (r1) begin qa1.push_back(old1); qb1.push_back(m1); end
      for (int b = 0; b < 4; b++) if (w1[b]) mdl[a1][8*b +: 8] = d1[8*b +: 8];
      for (int b = 0; b < 4; b++) if (w0[b]) mdl[a0][8*b +: 8] = d0[8*b +: 8];
    end
    addr0 = a0; din0 = d0; wr0 = w0; rd0 = r0;
    addr1 = a1; din1 = d1; wr1 = w1; rd1 = r1;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    addr0 = '0; din0 = '0; wr0 = '0; rd0 = 1'b0;
    addr1 = '0; din1 = '0; wr1 = '0; rd1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ready_a, ready_b, ready_c, va0, va1, vb0, vb1, coll_a, coll_b} !== 9'b0) begin
      n_err++; $display("FAIL reset_flags: got %b required 000000000",
                        {ready_a, ready_b, ready_c, va0, va1, vb0, vb1, coll_a, coll_b});
    end
    n_cmp++;
    if ({da0, da1, db0, db1} !== 128'h0) begin
      n_err++; $display("FAIL reset_data: got %h %h %h %h required all 0", da0, da1, db0, db1);
    end
  endtask

  task automatic test_clear_gating();
    int first;
    rst = 1'b1;
    addr0 = 4'd3; din0 = 32'h12345678; wr0 = 4'hF; rd0 = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    n_cmp++;
    if (ready_a !== 1'b0) begin n_err++; $display("FAIL clear_cycle7_ready: got %b required 0", ready_a); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ready_a !== 1'b0 || ready_c !== 1'b0) begin
      n_err++; $display("FAIL midclear_reset_ready: got a=%b c=%b required 0 0", ready_a, ready_c);
    end
    #2 rst = 1'b1;
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        n_cmp++;
        if (ready_c !== 1'b1) begin n_err++; $display("FAIL noclear_ready_first_edge: got %b required 1", ready_c); end
      end
      if (ready_a === 1'b1) first = i;
    end
    idle();
    n_cmp++;
    if (first != 17) begin n_err++; $display("FAIL clear_ready_edge: ready at edge %0d required 17 (0 = timeout)", first); end
    n_cmp++;
    if (ready_b !== 1'b1) begin n_err++; $display("FAIL clear_ready_b: got %b required 1", ready_b); end
    for (int i = 0; i < 16; i++) mdl[i] = 32'hA5A5A5A5;
    bench_ready = 1'b1;
  endtask

  task automatic test_clear_readback();
    for (int i = 0; i < 16; i++) acc(4'(i), 32'h0, 4'h0, 1'b1, 4'h0, 32'h0, 4'h0, 1'b0);
    idle(); idle();
  endtask

  task automatic test_byte_enables();
    acc(4'd0, 32'h0, 4'h0, 1'b0, 4'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    acc(4'd0, 32'h0, 4'h0, 1'b0, 4'd5, 32'h00001100, 4'h2, 1'b0);
    acc(4'd5, 32'h0, 4'h0, 1'b1, 4'd0, 32'h0, 4'h0, 1'b0);
    n_cmp++;
    if (va0 !== 1'b1 || vb0 !== 1'b0 || da0 !== 32'hDEAD11EF) begin
      n_err++; $display("FAIL be_latency1: va=%b vb=%b da=%h required 1 0 deadbeef->dead11ef", va0, vb0, da0);
    end
    idle();
    n_cmp++;
    if (va0 !== 1'b0 || vb0 !== 1'b1 || db0 !== 32'hDEAD11EF) begin
      n_err++; $display("FAIL be_latency2: va=%b vb=%b db=%h required 0 1 dead11ef", va0, vb0, db0);
    end
    idle();
    n_cmp++;
    if (vb0 !== 1'b0 || da0 !== 32'hDEAD11EF) begin
      n_err++; $display("FAIL be_pulse_hold: vb=%b da=%h required 0 dead11ef", vb0, da0);
    end
  endtask

  task automatic test_read_mode();
    acc(4'd9, 32'h11111111, 4'hF, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0);
    acc(4'd9, 32'h22222222, 4'hF, 1'b1, 4'd9, 32'h0, 4'h0, 1'b1);
    n_cmp++;
    if (da0 !== 32'h11111111 || da1 !== 32'h11111111) begin
      n_err++; $display("FAIL read_first: p0=%h p1=%h required 11111111 11111111", da0, da1);
    end
    idle();
    n_cmp++;
    if (db0 !== 32'h22222222 || db1 !== 32'h11111111) begin
      n_err++; $display("FAIL write_first: p0=%h p1=%h required 22222222 11111111", db0, db1);
    end
    idle();
  endtask

  task automatic test_collision();
    acc(4'd2, 32'hAAAAAAAA, 4'h3, 1'b0, 4'd2, 32'hBBBBBBBB, 4'h6, 1'b0);
    n_cmp++;
    if (coll_a !== 1'b1 || coll_b !== 1'b1) begin
      n_err++; $display("FAIL collision_pulse: a=%b b=%b required 1 1", coll_a, coll_b);
    end
    acc(4'd2, 32'h0, 4'h0, 1'b1, 4'd0, 32'h0, 4'h0, 1'b0);
    n_cmp++;
    if (coll_a !== 1'b0 || da0 !== 32'hA5BBAAAA) begin
      n_err++; $display("FAIL collision_once: coll=%b data=%h required 0 a5bbaaaa", coll_a, da0);
    end
    acc(4'd2, 32'hAAAAAAAA, 4'h3, 1'b0, 4'd2, 32'hBBBBBBBB, 4'hC, 1'b0);
    n_cmp++;
    if (coll_a !== 1'b0 || coll_b !== 1'b0) begin
      n_err++; $display("FAIL disjoint_no_collision: a=%b b=%b required 0 0", coll_a, coll_b);
    end
    acc(4'd2, 32'h0, 4'h0, 1'b1, 4'd0, 32'h0, 4'h0, 1'b0);
    idle(); idle();
  endtask

  task automatic test_back_to_back();
    int gaps = 0;
    for (int i = 0; i < 16; i++) begin
      acc(4'(i), 32'h0, 4'h0, 1'b1, 4'(15 - i), $urandom, 4'hF, 1'b0);
      if (va0 !== 1'b1) gaps++;
      if (i > 0 && vb0 !== 1'b1) gaps++;
    end
    idle();
    if (vb0 !== 1'b1) gaps++;
    if (va0 !== 1'b0) gaps++;
    idle();
    n_cmp++;
    if (gaps != 0) begin n_err++; $display("FAIL throughput_gaps: %0d missing or extra valid cycles, required 0", gaps); end
  endtask

  initial begin
    test_reset();
    test_clear_gating();
    test_clear_readback();
    test_byte_enables();
    test_read_mode();
    test_collision();
    test_back_to_back();
    repeat (4) idle();
    n_cmp++;
    if (qa0.size() + qa1.size() + qb0.size() + qb1.size() != 0) begin
      n_err++; $display("FAIL drain: %0d reads never returned, required 0",
                        qa0.size() + qa1.size() + qb0.size() + qb1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
